// File: rtl/exe_muldiv_pkg.sv
// Shared encodings and helpers for the sequential M-extension unit.
package exe_muldiv_pkg;

  typedef logic [2:0] op_t;
  typedef logic [2:0] state_t;

  // Operation codes
  localparam op_t OP_MUL    = 3'd0;
  localparam op_t OP_MULH   = 3'd1;
  localparam op_t OP_MULHSU = 3'd2;
  localparam op_t OP_MULHU  = 3'd3;
  localparam op_t OP_DIV    = 3'd4;
  localparam op_t OP_DIVU   = 3'd5;
  localparam op_t OP_REM    = 3'd6;
  localparam op_t OP_REMU   = 3'd7;

  // FSM state encoding
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_MUL  = 3'd1;
  localparam state_t ST_DIV  = 3'd2;
  localparam state_t ST_FIX  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // Divide and remainder ops share op[2]=1
  function automatic logic is_div(input op_t op);
    return op[2];
  endfunction

  // Remainder ops return the remainder instead of the quotient
  function automatic logic is_rem(input op_t op);
    return op[2] & op[1];
  endfunction

  // DIV and REM treat operands as two's complement
  function automatic logic is_signed_div(input op_t op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes.
// One quotient bit per step; last_o flags the final step.
module muldiv_div_core
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            last_o
);

  logic [XLEN:0]      rem_q, rem_d;
  logic [XLEN-1:0]    quot_q, quot_d;
  logic [XLEN-1:0]    div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]      shifted;
  logic [XLEN+1:0]    diff;

  // Trial subtraction; one extra bit so the sign of the difference is unambiguous
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    shifted = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, div_q};
    rem_d   = rem_q;
    quot_d  = quot_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      div_d  = divisor_i;
      cnt_d  = CNT_W'(XLEN - 1);
    end else if (step_i) begin
      if (!diff[XLEN+1]) begin
        rem_d  = diff[XLEN:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = shifted;
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q[XLEN-1:0];
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/exe_muldiv_seq.sv
// Self-sequencing multi-cycle multiply/divide unit for the EXE stage.
// Owns its FSM, a multicycle multiply path, the divider core, sign fix-up
// and the result hold under downstream stall.
module exe_muldiv_seq
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int CNT_W       = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_idx_i,
  input  logic            st_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_idx_o
);

  localparam int MCNT_INIT = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            negq_q, negq_d, negr_q, negr_d;
  logic [1:0]      mcnt_q, mcnt_d;

  logic            accept;
  logic            div_load, div_step, div_last;
  logic [XLEN-1:0] div_quot, div_rem;

  // Multiply path: operands come straight from the inputs in IDLE (single-cycle case)
  // and from the latched copies afterwards; the product is a multicycle path.
  op_t               mul_op;
  logic [XLEN-1:0]   mul_a, mul_b;
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_ea, mul_eb, mul_prod;
  logic [XLEN-1:0]   mul_res;

  // Divide preparation on the incoming operands
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic [XLEN-1:0] fix_quot, fix_rem, fix_res;

  assign accept = (state_q == ST_IDLE) & start_i & ~flush_i;

  // Sign-extend operands to 2*XLEN and take the low 2*XLEN bits of the product
  always_comb begin
    mul_op   = (state_q == ST_IDLE) ? op_i : op_q;
    mul_a    = (state_q == ST_IDLE) ? a_i  : opa_q;
    mul_b    = (state_q == ST_IDLE) ? b_i  : opb_q;
    mul_sa   = (mul_op != OP_MULHU);
    mul_sb   = (mul_op == OP_MUL) || (mul_op == OP_MULH);
    mul_ea   = {{XLEN{mul_sa & mul_a[XLEN-1]}}, mul_a};
    mul_eb   = {{XLEN{mul_sb & mul_b[XLEN-1]}}, mul_b};
    mul_prod = mul_ea * mul_eb;
    mul_res  = (mul_op == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // Magnitudes, sign flags and the two special-case results
  always_comb begin
    a_neg    = is_signed_div(op_i) & a_i[XLEN-1];
    b_neg    = is_signed_div(op_i) & b_i[XLEN-1];
    a_mag    = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag    = b_neg ? (~b_i + 1'b1) : b_i;
    div_zero = (b_i == '0);
    div_ovf  = is_signed_div(op_i) && (a_i == INT_MIN) && (b_i == '1);
    if (div_zero) spec_res = is_rem(op_i) ? a_i : '1;
    else          spec_res = is_rem(op_i) ? '0  : a_i;
  end

  // Sign fix-up of the magnitude quotient/remainder
  always_comb begin
    fix_quot = negq_q ? (~div_quot + 1'b1) : div_quot;
    fix_rem  = negr_q ? (~div_rem + 1'b1)  : div_rem;
    fix_res  = is_rem(op_q) ? fix_rem : fix_quot;
  end

  // FSM next-state and result capture; flush wins over everything
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rd_d     = rd_q;
    result_d = result_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    mcnt_d   = mcnt_q;
    div_load = 1'b0;
    div_step = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_d   = op_i;
            opa_d  = a_i;
            opb_d  = b_i;
            rd_d   = rd_idx_i;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            if (!is_div(op_i)) begin
              if (MUL_LATENCY == 1) begin
                state_d  = ST_DONE;
                result_d = mul_res;
              end else begin
                state_d = ST_MUL;
                mcnt_d  = 2'(MCNT_INIT);
              end
            end else if (div_zero || div_ovf) begin
              state_d  = ST_DONE;
              result_d = spec_res;
            end else begin
              state_d  = ST_DIV;
              div_load = 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mcnt_q == '0) begin
            state_d  = ST_DONE;
            result_d = mul_res;
          end else begin
            mcnt_d = mcnt_q - 1'b1;
          end
        end
        ST_DIV: begin
          div_step = 1'b1;
          if (div_last) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d  = ST_DONE;
          result_d = fix_res;
        end
        ST_DONE: begin
          if (!st_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      opa_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      mcnt_q   <= mcnt_d;
    end
  end

  muldiv_div_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quot_o     (div_quot),
    .rem_o      (div_rem),
    .last_o     (div_last)
  );

  assign busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign stall_o  = busy_o | accept;
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  assign rd_idx_o = rd_q;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Randomised scoreboard bench for exe_muldiv_seq (XLEN=32, MUL_LATENCY=2).
module tb_exe_muldiv_seq;

  localparam int XLEN = 32;
  localparam int MUL_LAT = 2;
  localparam int PERIOD = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush_i = 1'b0;
  logic            start_i = 1'b0;
  logic [2:0]      op_i = '0;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic [4:0]      rd_idx_i = '0;
  logic            st_i = 1'b0;
  logic            busy_o, stall_o, done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_idx_o;

  exe_muldiv_seq #(.XLEN(XLEN), .MUL_LATENCY(MUL_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .rd_idx_i (rd_idx_i),
    .st_i     (st_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_idx_o (rd_idx_o)
  );

  always #(PERIOD/2) clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    time         acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the instruction definitions
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  // Monitor: pops on each new result and checks hold behaviour while it is shown
  initial begin
    exp_t cur;
    logic prev_done = 1'b0;
    logic prev_st   = 1'b0;
    logic [31:0] prev_res = '0;
    forever begin
      @(negedge clk);
      #1;
      if (done_o && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("result", result_o, cur.res);
          check("rd_idx", rd_idx_o, cur.tag);
          check("latency", ($time - cur.acc + PERIOD/2) / PERIOD, cur.lat);
        end
        check("stall_in_done", stall_o, 0);
      end else if (done_o && prev_done) begin
        check("done_only_when_stalled", prev_st, 1);
        check("result_hold", result_o, prev_res);
      end else if (!done_o && prev_done && prev_st) begin
        check("done_dropped_under_stall", 0, 1);
      end
      prev_done = done_o;
      prev_st   = st_i;
      prev_res  = result_o;
    end
  end

  // Issue one op, wait for its result and hold it for stall_cyc extra cycles
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int stall_cyc, input bit junk);
    exp_t e;
    int waited;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_idx_i = tag;
    st_i = (stall_cyc > 0);
    #1 check("stall_on_accept", stall_o, 1);
    @(posedge clk);
    e.res = ref_result(op, a, b);
    e.tag = tag;
    e.lat = ref_latency(op, a, b);
    e.acc = $time;
    exp_q.push_back(e);
    @(negedge clk);
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; rd_idx_i = 5'($urandom); op_i = 3'($urandom);
    waited = 0;
    while (!done_o && waited < 100) begin
      check("stall_while_busy", {stall_o, busy_o}, 2'b11);
      start_i = (junk && waited == 5);
      @(negedge clk);
      waited++;
    end
    start_i = 1'b0;
    if (waited >= 100) check("done_timeout", 0, 1);
    repeat (stall_cyc) @(negedge clk);
    st_i = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          pick;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_done", done_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_stall", stall_o, 0);
    check("reset_result", result_o, 0);
    check("reset_rd", rd_idx_o, 0);
    reset = 1'b0;

    // Directed cases
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0, 0); // MULH
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd2, 0, 0);         // DIV -7/2
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, 0);         // REM -7%2
    run_op(3'd5, 32'd100, 32'd0, 5'd4, 0, 0);               // DIVU by zero
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, 0); // REM overflow
    run_op(3'd5, 32'd1000, 32'd7, 5'd6, 3, 1);              // DIVU held, junk start

    // Flush together with start during divide
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; a_i = 32'd12345; b_i = 32'd17; rd_idx_i = 5'd7;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd4;
    @(posedge clk);
    @(negedge clk);
    check("flush_done", done_o, 0);
    check("flush_busy", busy_o, 0);
    flush_i = 1'b0; start_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("flush_quiet", {busy_o, done_o}, 2'b00);
    end

    // Reset during a multiply
    run_op(3'd0, 32'd6, 32'd7, 5'd8, 0, 0);
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd1; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0; rd_idx_i = 5'd9;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_result", result_o, 0);
    check("midreset_rd", rd_idx_o, 0);
    check("midreset_flags", {done_o, busy_o, stall_o}, 3'b000);
    reset = 1'b0;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0, 0); // MULHU

    // Randomised ops with corner-biased operands
    for (int i = 0; i < 60; i++) begin
      rop  = 3'($urandom);
      ra   = $urandom;
      rb   = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) rb = 32'd0;
      if (pick == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (pick == 2) rb = 32'($urandom_range(1, 15));
      if (pick == 3) ra = 32'h8000_0000;
      if (pick == 4) rb = rb | 32'h8000_0000;
      run_op(rop, ra, rb, 5'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_seq.md
Name: exe_muldiv_seq

Overview:
Self-sequencing multi-cycle M-extension unit for the EXE stage. It is a parametrised successor to the ID-driven mul_state/d_init/d_advance control scheme: the unit takes one start pulse and runs its own FSM and counter. It produces results for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. While busy it raises a stall to the hazard unit and holds its result under downstream stall.

Parameters:
XLEN, 32, operand/result width (>=8, power of 2)
MUL_LATENCY, 2, cycles from accept to done for multiplies (1..4)
CNT_W, $clog2(XLEN)+1, width of the divide iteration counter (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush_i  in  1  abort current op; drop pending result
start_i  in  1  request new op (sampled only in IDLE)
op_i  in  3  operation code (package encoding)
a_i  in  XLEN  operand rs1
b_i  in  XLEN  operand rs2
rd_idx_i  in  5  destination register tag
st_i  in  1  downstream stall; hold result while high
busy_o  out  1  FSM in MUL, DIV or FIX
stall_o  out  1  pipeline stall request to hazard unit
done_o  out  1  result valid
result_o  out  XLEN  result
rd_idx_o  out  5  tag of the result

Behaviour:
- Reset: state=IDLE; busy_o=0, stall_o=0, done_o=0, result_o=0, rd_idx_o=0, counter=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + start_i & ~flush_i: latch op, operands, tag. stall_o=1 combinationally in this same cycle.
  - Multiply op -> MUL.
  - Divide/rem with b=0 or signed overflow -> DONE directly.
  - Otherwise -> DIV, counter=XLEN-1.
- MUL: full 2*XLEN product from sign-extended operands (signed/signed, signed/unsigned, unsigned/unsigned per op).
  - Register chain of MUL_LATENCY-1 stages, then DONE.
  - done_o first high exactly MUL_LATENCY cycles after the accepting edge.
  - MUL returns the low half; MULH* return the high half.
- DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, counter decrements. Counter==0 -> FIX.
- FIX: quotient negated if operand signs differ (signed ops); remainder takes the sign of the dividend. Then DONE.
  - Normal-divide latency: done_o high XLEN+2 cycles after the accepting edge.
- Special cases:
  - Divide by zero: quotient = all ones; remainder = a_i.
  - Signed overflow (a=-2^(XLEN-1), b=-1): quotient = a_i; remainder = 0.
  - Both special cases: done_o high 1 cycle after accept.
- DONE: done_o=1 and result_o/rd_idx_o stable. If st_i=0, return to IDLE next cycle (one-cycle pulse); if st_i=1, stay in DONE.
- start_i in any non-IDLE state is ignored: no re-latch, no corruption.
- stall_o = busy_o | (state==IDLE & start_i & ~flush_i).
  - stall_o is low in DONE, so the consumer can proceed.
- flush_i: has priority over everything else, including start_i in the same cycle. Next state=IDLE; done_o=0 the following cycle; in-flight result discarded.
- reset mid-operation: identical to flush_i plus result_o/rd_idx_o cleared.
- Back-to-back ops: new start_i is accepted on the first IDLE cycle after DONE. Minimum spacing = latency+1.
- Widths: product internal 2*XLEN; divider remainder register XLEN+1 bits; all outputs XLEN.

Decomposition:
- Package exe_muldiv_pkg holds:
  - op encodings: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
  - state encoding
  - helper function is_div(op)
- Sub-module muldiv_div_core holds the iterative restoring divider: load, step and counter, with quotient/remainder outputs and a last flag.
- Top-level holds the FSM, the multiply pipeline, the sign fix and the output hold.

Test Plan:
- XLEN=32, MUL_LATENCY=2: MULH a=0x80000000, b=0x80000000 -> done_o 2 cycles after accept, result 0x40000000, stall_o high in between.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done_o at accept+34, result 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF.
- DIVU a=100, b=0 -> 0xFFFFFFFF after 1 cycle. REM a=0x80000000, b=0xFFFFFFFF -> 0 after 1 cycle.
- DIVU a=1000, b=7 with st_i held 3 cycles at done -> done_o and result 142 stay stable 4 cycles, then a single IDLE return. A start_i pulsed during DIV is ignored.
- flush_i asserted at DIV iteration 10 together with start_i -> IDLE next cycle, no done_o, no new op accepted.
- reset asserted during MUL -> all outputs 0 next cycle. A subsequent MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
